// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Purpose:
//   Handshaked ALU. Single-cycle operations (ADD..AND) and illegal opcodes
//   complete one cycle after acceptance. With the ALU_MULDIV_EN macro defined,
//   MUL/MULHU/DIVU/REMU run on an iterative one-bit-per-cycle datapath
//   (shift-add multiply, restoring divide) for exactly XLEN cycles.
//   Without ALU_MULDIV_EN those four opcodes are reported as illegal and the
//   BUSY state and iteration datapath do not exist.
//
// Configuration macro: ALU_MULDIV_EN
//
// Parameters:
//   XLEN       operand/result width (8..64, power of two)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present on op/a/b
//   in_ready   block accepts a request this cycle (IDLE only)
//   op         4-bit operation code
//   a, b       operands, sampled on accept
//   out_valid  result/zero/err hold a completed operation
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   zero       result == 0
//   err        illegal opcode
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t          state_r;
    state_t          state_nx_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            err_r;

    logic            accept_s;
    logic            muldiv_op_s;
    logic            illegal_s;
    logic [XLEN-1:0] alu_res_s;
    logic            load_s;
    logic [XLEN-1:0] load_val_s;
    logic            load_err_s;

    // Single-cycle operations; anything not listed (including the
    // multiply/divide codes, which never use this path) yields zero.
    function automatic logic [XLEN-1:0] alu_calc(
        input logic [3:0]      f_op,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y
    );
        logic [SHW-1:0] sh;
        sh = y[SHW-1:0];
        case (f_op)
            4'd0:    alu_calc = x + y;
            4'd1:    alu_calc = x - y;
            4'd2:    alu_calc = ($signed(x) < $signed(y)) ? ONE_W : ZERO_W;
            4'd3:    alu_calc = x << sh;
            4'd4:    alu_calc = (x < y) ? ONE_W : ZERO_W;
            4'd5:    alu_calc = x ^ y;
            4'd6:    alu_calc = x >> sh;
            4'd7:    alu_calc = $unsigned($signed(x) >>> sh);
            4'd8:    alu_calc = x | y;
            4'd9:    alu_calc = x & y;
            default: alu_calc = ZERO_W;
        endcase
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign err       = err_r;

    // in_ready_r is high exactly when the FSM sits in IDLE.
    assign accept_s  = in_valid && in_ready_r;
    assign alu_res_s = alu_calc(op, a, b);

`ifdef ALU_MULDIV_EN
    localparam int CNTW = $clog2(XLEN) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0] cnt_r;
    logic            is_div_r;
    logic            take_hi_r;
    logic [XLEN-1:0] opnd_r;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN+1:0] div_diff_s;
    logic [XLEN-1:0] hi_nx_s;
    logic [XLEN-1:0] lo_nx_s;
    logic [XLEN-1:0] iter_res_s;
    logic            finish_s;

    assign muldiv_op_s = (op >= 4'd10) && (op <= 4'd13);
    assign illegal_s   = (op >= 4'd14);
    assign finish_s    = (state_r == S_BUSY) && (cnt_r == CNT_LAST);

    // One iteration step. hi:lo is the product accumulator (multiply) or
    // remainder:quotient (divide). The divide subtraction is one bit wider
    // than the shifted remainder so a zero divisor never looks negative;
    // that makes b==0 naturally give quotient all-ones and remainder a.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + {1'b0, opnd_r};
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
        hi_nx_s     = hi_r;
        lo_nx_s     = lo_r;
        if (is_div_r) begin
            if (div_diff_s[XLEN+1]) begin
                hi_nx_s = div_shift_s[XLEN-1:0];
                lo_nx_s = {lo_r[XLEN-2:0], 1'b0};
            end else begin
                hi_nx_s = div_diff_s[XLEN-1:0];
                lo_nx_s = {lo_r[XLEN-2:0], 1'b1};
            end
        end else begin
            if (lo_r[0]) begin
                hi_nx_s = mul_sum_s[XLEN:1];
                lo_nx_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
            end else begin
                hi_nx_s = {1'b0, hi_r[XLEN-1:1]};
                lo_nx_s = {hi_r[0], lo_r[XLEN-1:1]};
            end
        end
        iter_res_s = take_hi_r ? hi_nx_s : lo_nx_s;
    end

    // Iteration registers: seeded on accept, stepped once per BUSY cycle.
    // op[2] separates divide (12,13) from multiply (10,11); op[0] picks the
    // high half (MULHU product high / REMU remainder).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CNTW{1'b0}};
            is_div_r  <= 1'b0;
            take_hi_r <= 1'b0;
            opnd_r    <= ZERO_W;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
        end else if (accept_s) begin
            cnt_r     <= {CNTW{1'b0}};
            is_div_r  <= op[2];
            take_hi_r <= op[0];
            hi_r      <= ZERO_W;
            lo_r      <= op[2] ? a : b;
            opnd_r    <= op[2] ? b : a;
        end else if (state_r == S_BUSY) begin
            cnt_r     <= cnt_r + CNT_ONE;
            hi_r      <= hi_nx_s;
            lo_r      <= lo_nx_s;
        end
    end
`else
    assign muldiv_op_s = 1'b0;
    assign illegal_s   = (op >= 4'd10);
`endif

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
`ifdef ALU_MULDIV_EN
                    if (muldiv_op_s) begin
                        state_nx_s = S_BUSY;
                    end else begin
                        state_nx_s = S_DONE;
                    end
`else
                    state_nx_s = S_DONE;
`endif
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_BUSY;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Select what, if anything, is written into the output registers.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = alu_res_s;
        load_err_s = illegal_s;
        if (accept_s && !muldiv_op_s) begin
            load_s = 1'b1;
        end else begin
`ifdef ALU_MULDIV_EN
            if (finish_s) begin
                load_s     = 1'b1;
                load_val_s = iter_res_s;
                load_err_s = 1'b0;
            end else begin
                load_s = 1'b0;
            end
`else
            load_s = 1'b0;
`endif
        end
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == S_IDLE);
            out_valid_r <= (state_nx_s == S_DONE);
        end
    end

    // Output registers; they hold their value through DONE backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= ZERO_W;
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (load_s) begin
            result_r <= load_val_s;
            zero_r   <= (load_val_s == ZERO_W);
            err_r    <= load_err_s;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//
// Directed-vector bench for alu_multicycle (XLEN=32). The driver pushes the
// hand-computed expected response into a scoreboard queue; a monitor running
// on the falling edge compares whatever the DUT presents against the queue
// head and pops it on the output handshake.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            zero;
        logic            err;
        int              lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      op = 4'd0;
    logic [XLEN-1:0] a = 32'd0;
    logic [XLEN-1:0] b = 32'd0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    time  acc_q[$];

    alu_multicycle #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Issue one request once in_ready is seen, and record its expected response.
    task automatic send(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] r, input logic e, input int lat);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            exp_q.push_back('{res: r, zero: (r == 32'd0), err: e, lat: lat});
            in_valid = 1'b1;
            op = o;
            a  = x;
            b  = y;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor / scoreboard checker.
    initial begin
        exp_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back($time + 5);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = exp_q[0];
                        chk("result", 64'(result), 64'(e.res));
                        chk("zero", {63'd0, zero}, {63'd0, e.zero});
                        chk("err", {63'd0, err}, {63'd0, e.err});
                        if (!seen) begin
                            seen = 1'b1;
                            if (acc_q.size() != 0) begin
                                lat = int'(($time - acc_q[0] + 5) / 10);
                                chk("latency", 64'(lat), 64'(e.lat));
                            end else begin
                                chk("accept_seen", 64'(acc_q.size()), 64'd1);
                            end
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            if (acc_q.size() != 0) void'(acc_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset values, before any clock edge.
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Single-cycle operations.
        send(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        send(4'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
        send(4'd2, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        send(4'd4, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        send(4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1);
        send(4'd3, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1);
        send(4'd6, 32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0, 1);
        send(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
        send(4'd8, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1);
        send(4'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
        send(4'd14, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        drain();

        // Multiply/divide group.
`ifdef ALU_MULDIV_EN
        send(4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 33);
        send(4'd11, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 1'b0, 33);
        send(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        send(4'd12, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        send(4'd13, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        send(4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        send(4'd13, 32'd5, 32'd0, 32'd5, 1'b0, 33);
`else
        send(4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 1'b1, 1);
        send(4'd11, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 1'b1, 1);
        send(4'd12, 32'd100, 32'd7, 32'h0000_0000, 1'b1, 1);
        send(4'd13, 32'd5, 32'd0, 32'h0000_0000, 1'b1, 1);
`endif
        drain();

        // Backpressure: result held, in_ready low, new requests ignored.
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1);
        in_valid = 1'b1;
        op = 4'd1;
        a  = 32'h55;
        b  = 32'h11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_out_valid_low", {63'd0, out_valid}, 64'd0);
        drain();

        // Reset pulsed ten cycles into an operation aborts it.
        out_ready = 1'b0;
`ifdef ALU_MULDIV_EN
        send(4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0, 33);
`else
        send(4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000, 1'b1, 1);
`endif
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_zero", {63'd0, zero}, 64'd0);
        chk("abort_err", {63'd0, err}, 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_result", {63'd0, out_valid}, 64'd0);
        send(4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1);
        send(4'd15, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 op  input  4  operation code (REQ-010).
REQ-007 a, b  input  XLEN each  operands, sampled only on accept.
REQ-008 out_valid  output  1  result/zero/err hold a completed operation.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-009a result  output  XLEN; zero  output  1; err  output  1  registered result, result==0 flag, illegal-op flag.

Function
REQ-010 Opcodes: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLL, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned), 12 DIVU, 13 REMU, 14-15 illegal.
REQ-011 Shift amount = b[$clog2(XLEN)-1:0]; upper bits of b ignored.
REQ-012 Arithmetic is modulo 2^XLEN; ADD/SUB carry discarded.
REQ-013 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept = in_valid && in_ready; op, a, b latched on accept.
REQ-015 Opcodes 0-9 and illegal: IDLE -> DONE on accept; out_valid asserted the cycle after accept (latency 1).
REQ-016 Opcodes 10-13: IDLE -> BUSY on accept; iterative one-bit-per-cycle shift-add multiply or restoring divide; exactly XLEN cycles in BUSY, then DONE; out_valid asserted XLEN+1 cycles after accept.
REQ-017 Iteration counter width $clog2(XLEN)+1, cleared on accept, BUSY -> DONE when counter reaches XLEN-1 on that edge.
REQ-018 DONE: result/zero/err stable while out_valid && !out_ready; DONE -> IDLE on out_ready; no new request accepted in that same cycle.
REQ-019 DIVU with b==0: result = all ones; REMU with b==0: result = a; err = 0; latency unchanged.
REQ-020 Illegal op: result = 0, zero = 1, err = 1.
REQ-021 zero computed from the final registered result, valid whenever out_valid = 1.
REQ-022 in_valid/op/a/b changes while not in IDLE have no effect.
REQ-023 out_ready while not in DONE has no effect.

Reset
REQ-024 rst asserted: state = IDLE immediately, out_valid = 0, result = 0, zero = 0, err = 0, counter = 0, regardless of clock.
REQ-025 rst during BUSY or DONE aborts the operation; no result is ever presented for it.
REQ-026 in_ready = 1 from the first cycle after rst deasserts.

Configuration
REQ-027 Macro ALU_MULDIV_EN: defined -> opcodes 10-13 implemented per REQ-016/019.
REQ-028 ALU_MULDIV_EN undefined -> opcodes 10-13 treated as illegal (REQ-020, latency 1); BUSY state and iteration datapath not instantiated.

Verification
REQ-029 XLEN=32, op=0, a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid next cycle, result=0, zero=1, err=0.
REQ-030 op=2 a=0xFFFFFFFE b=1 -> result=1; op=4 same operands -> result=0; op=7 a=0x80000000 b=0x24 -> result=0xF8000000.
REQ-031 ALU_MULDIV_EN, op=10 a=0x10001 b=0x10001 -> result=0x00020001 exactly 33 cycles after accept; op=11 same operands -> result=0x1.
REQ-032 ALU_MULDIV_EN, op=12 a=100 b=7 -> 14; op=13 -> 2; op=12 b=0 -> 0xFFFFFFFF; op=13 a=5 b=0 -> 5.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> result/zero/err stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-034 rst pulsed mid-BUSY (cycle 10 of MUL) -> out_valid=0 and in_ready=1 after release; next ADD 3+4 -> 7; op=15 -> result=0, err=1.
